pipeline_hazard_controller: RTL and testbench

- Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Drives write-enable and bubble-insert controls for PC, IF_ID, ID_EX, EX_MEM and MEM_WB from:
  - load-use hazards
  - taken branches/jumps resolved in EX
  - instruction/data memory busywait
  - multi-cycle MUL/DIV ops in EX
- Sits beside the pipeline registers in the CPU top; replaces the per-register BUSYWAIT gating.

---
 rtl/cpu_ctrl_pkg.sv | 12 +
 rtl/load_use_detector.sv | 14 +
 rtl/pipeline_hazard_controller.sv | 127 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the RV32 pipeline control path.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN            = 2'd0,
    MULDIV_WAIT    = 2'd1,
    MULDIV_RELEASE = 2'd2
  } ctrl_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/load_use_detector.sv
// Flags a load in EX whose destination is read by the instruction in ID.
module load_use_detector (
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  logic [4:0] i_rd,
  input  logic       i_memRead,
  output logic       o_hazard
);

  // x0 is never a real dependency, so a load targeting it cannot stall.
  assign o_hazard = i_memRead && (i_rd != 5'd0) &&
                    ((i_rd == i_rs1) || (i_rd == i_rs2));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer: derives per-register write-enable and
// bubble controls from hazards, branches, memory waits and MUL/DIV ops.
module pipeline_hazard_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int MULDIV_LATENCY = 4,
  parameter int CNT_W          = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       IF_ID_RS1,
  input  logic [4:0]       IF_ID_RS2,
  input  logic [4:0]       ID_EX_RD,
  input  logic             ID_EX_MEM_READ,
  input  logic             ID_EX_MULDIV,
  input  logic             BRANCH_TAKEN,
  input  logic             IMEM_BUSYWAIT,
  input  logic             DMEM_BUSYWAIT,
  output logic             PC_WRITE_EN,
  output logic             IF_ID_WRITE_EN,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_WRITE_EN,
  output logic             ID_EX_FLUSH,
  output logic             EX_MEM_WRITE_EN,
  output logic             EX_MEM_FLUSH,
  output logic             MEM_WB_WRITE_EN,
  output logic [1:0]       STATE_OUT,
  output logic [CNT_W-1:0] STALL_COUNT
);

  localparam int MCNT_W = ($clog2(MULDIV_LATENCY) < 1) ? 1 : $clog2(MULDIV_LATENCY);
  localparam logic [MCNT_W-1:0] MCNT_LOAD = MCNT_W'(MULDIV_LATENCY - 2);

  ctrl_state_t       r_state;
  ctrl_state_t       w_nextState;
  logic [MCNT_W-1:0] r_mcnt;
  logic [MCNT_W-1:0] w_nextMcnt;
  logic [CNT_W-1:0]  r_stallCount;
  logic              w_loadUse;

  load_use_detector u_loadUse (
    .i_rs1     (IF_ID_RS1),
    .i_rs2     (IF_ID_RS2),
    .i_rd      (ID_EX_RD),
    .i_memRead (ID_EX_MEM_READ),
    .o_hazard  (w_loadUse)
  );

  always_comb begin
    w_nextState     = r_state;
    w_nextMcnt      = r_mcnt;
    PC_WRITE_EN     = 1'b1;
    IF_ID_WRITE_EN  = 1'b1;
    IF_ID_FLUSH     = 1'b0;
    ID_EX_WRITE_EN  = 1'b1;
    ID_EX_FLUSH     = 1'b0;
    EX_MEM_WRITE_EN = 1'b1;
    EX_MEM_FLUSH    = 1'b0;
    MEM_WB_WRITE_EN = 1'b1;

    if (RESET) begin
      PC_WRITE_EN     = 1'b0;
      IF_ID_WRITE_EN  = 1'b0;
      ID_EX_WRITE_EN  = 1'b0;
      EX_MEM_WRITE_EN = 1'b0;
      MEM_WB_WRITE_EN = 1'b0;
      IF_ID_FLUSH     = 1'b1;
      ID_EX_FLUSH     = 1'b1;
      EX_MEM_FLUSH    = 1'b1;
    end else if (DMEM_BUSYWAIT) begin
      PC_WRITE_EN     = 1'b0;
      IF_ID_WRITE_EN  = 1'b0;
      ID_EX_WRITE_EN  = 1'b0;
      EX_MEM_WRITE_EN = 1'b0;
      MEM_WB_WRITE_EN = 1'b0;
    end else if (r_state == MULDIV_WAIT) begin
      PC_WRITE_EN    = 1'b0;
      IF_ID_WRITE_EN = 1'b0;
      ID_EX_WRITE_EN = 1'b0;
      EX_MEM_FLUSH   = 1'b1;
      w_nextMcnt     = (r_mcnt == '0) ? '0 : r_mcnt - MCNT_W'(1);
      // Leave when the decremented count reaches zero so that the issue
      // cycle, the wait cycles and the release cycle total MULDIV_LATENCY.
      if (r_mcnt <= MCNT_W'(1)) begin
        w_nextState = MULDIV_RELEASE;
      end
    end else begin
      w_nextState = RUN;
      if ((r_state == RUN) && ID_EX_MULDIV) begin
        PC_WRITE_EN    = 1'b0;
        IF_ID_WRITE_EN = 1'b0;
        ID_EX_WRITE_EN = 1'b0;
        EX_MEM_FLUSH   = 1'b1;
        w_nextState    = MULDIV_WAIT;
        w_nextMcnt     = MCNT_LOAD;
      end else if (BRANCH_TAKEN) begin
        IF_ID_FLUSH = 1'b1;
        ID_EX_FLUSH = 1'b1;
      end else if (w_loadUse) begin
        PC_WRITE_EN    = 1'b0;
        IF_ID_WRITE_EN = 1'b0;
        ID_EX_FLUSH    = 1'b1;
      end else if (IMEM_BUSYWAIT) begin
        PC_WRITE_EN = 1'b0;
        IF_ID_FLUSH = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= RUN;
      r_mcnt       <= '0;
      r_stallCount <= '0;
    end else begin
      r_state <= w_nextState;
      r_mcnt  <= w_nextMcnt;
      if (!PC_WRITE_EN && (r_stallCount != '1)) begin
        r_stallCount <= r_stallCount + CNT_W'(1);
      end
    end
  end

  assign STATE_OUT   = r_state;
  assign STALL_COUNT = r_stallCount;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: each directed vector queues its hand-computed response,
// and an independent negedge monitor pops and compares it.
module tb_pipeline_hazard_controller;

  // Control order: PC, IF_ID_WE, IF_ID_FL, ID_EX_WE, ID_EX_FL, EX_MEM_WE, EX_MEM_FL, MEM_WB_WE
  localparam logic [7:0] C_RST = 8'b00101010;
  localparam logic [7:0] C_RUN = 8'b11010101;
  localparam logic [7:0] C_FRZ = 8'b00000000;
  localparam logic [7:0] C_MDW = 8'b00000111;
  localparam logic [7:0] C_BR  = 8'b11111101;
  localparam logic [7:0] C_LU  = 8'b00011101;
  localparam logic [7:0] C_IM  = 8'b01110101;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [1:0]  st;
    logic        chkCnt;
    logic [31:0] cnt;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [4:0]  ifIdRs1 = '0, ifIdRs2 = '0, idExRd = '0;
  logic        idExMemRead = 1'b0, idExMuldiv = 1'b0, branchTaken = 1'b0;
  logic        imemBusy = 1'b0, dmemBusy = 1'b0;
  logic        pcWe, ifIdWe, ifIdFl, idExWe, idExFl, exMemWe, exMemFl, memWbWe;
  logic [1:0]  stateOut;
  logic [31:0] stallCount;

  exp_t expQ[$];
  logic vecValid = 1'b0;
  int   vecCount = 0;
  int   missCount = 0;

  pipeline_hazard_controller #(.MULDIV_LATENCY(4), .CNT_W(32)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .IF_ID_RS1       (ifIdRs1),
    .IF_ID_RS2       (ifIdRs2),
    .ID_EX_RD        (idExRd),
    .ID_EX_MEM_READ  (idExMemRead),
    .ID_EX_MULDIV    (idExMuldiv),
    .BRANCH_TAKEN    (branchTaken),
    .IMEM_BUSYWAIT   (imemBusy),
    .DMEM_BUSYWAIT   (dmemBusy),
    .PC_WRITE_EN     (pcWe),
    .IF_ID_WRITE_EN  (ifIdWe),
    .IF_ID_FLUSH     (ifIdFl),
    .ID_EX_WRITE_EN  (idExWe),
    .ID_EX_FLUSH     (idExFl),
    .EX_MEM_WRITE_EN (exMemWe),
    .EX_MEM_FLUSH    (exMemFl),
    .MEM_WB_WRITE_EN (memWbWe),
    .STATE_OUT       (stateOut),
    .STALL_COUNT     (stallCount)
  );

  always #5 CLK = ~CLK;

  task automatic applyStimulus(
    input logic       rst,
    input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
    input logic       memRead, input logic muldiv, input logic br,
    input logic       imem, input logic dmem,
    input logic [7:0] eCtrl, input logic [1:0] eSt,
    input logic       eChk, input logic [31:0] eCnt
  );
    exp_t e;
    @(posedge CLK);
    #1;
    RESET       = rst;
    ifIdRs1     = rs1;
    ifIdRs2     = rs2;
    idExRd      = rd;
    idExMemRead = memRead;
    idExMuldiv  = muldiv;
    branchTaken = br;
    imemBusy    = imem;
    dmemBusy    = dmem;
    e.ctrl   = eCtrl;
    e.st     = eSt;
    e.chkCnt = eChk;
    e.cnt    = eCnt;
    expQ.push_back(e);
    vecValid = 1'b1;
  endtask

  task automatic idle(input logic [7:0] eCtrl, input logic [1:0] eSt, input logic [31:0] eCnt);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, eCtrl, eSt, 1, eCnt);
  endtask

  task automatic muldivVec(input logic md, input logic [1:0] eSt, input logic [31:0] eCnt);
    applyStimulus(0, 0, 0, 0, 0, md, 0, 0, 0, C_MDW, eSt, 1, eCnt);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [7:0] act;
    act = {pcWe, ifIdWe, ifIdFl, idExWe, idExFl, exMemWe, exMemFl, memWbWe};
    vecCount++;
    if ((act !== e.ctrl) || (stateOut !== e.st) ||
        (e.chkCnt && (stallCount !== e.cnt))) begin
      missCount++;
      $display("[TB] FAIL vec%0d: ctrl=%b state=%0d stall=%0d, required ctrl=%b state=%0d stall=%0d (checked=%0b)",
               vecCount, act, stateOut, stallCount, e.ctrl, e.st, e.cnt, e.chkCnt);
    end
  endtask

  // Monitor: one queued expectation per cycle in which a vector is presented.
  always @(negedge CLK) begin
    if (vecValid) begin
      if (expQ.size() == 0) begin
        vecCount++;
        missCount++;
        $display("[TB] FAIL underflow: output presented with empty scoreboard");
      end else begin
        checkOutput(expQ.pop_front());
      end
    end
  end

  initial begin
    @(posedge CLK);
    // Reset held two cycles; counter is only defined after the first edge.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 2'd0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 2'd0, 1, 0);
    idle(C_RUN, 2'd0, 0);
    // Load-use via rs2, then rd=x0, then via rs1, then non-load.
    applyStimulus(0, 0, 5, 5, 1, 0, 0, 0, 0, C_LU,  2'd0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, C_RUN, 2'd0, 1, 1);
    applyStimulus(0, 7, 3, 7, 1, 0, 0, 0, 0, C_LU,  2'd0, 1, 1);
    applyStimulus(0, 0, 5, 5, 0, 0, 0, 0, 0, C_RUN, 2'd0, 1, 2);
    // Branch beats a simultaneous load-use.
    applyStimulus(0, 0, 5, 5, 1, 0, 1, 0, 0, C_BR,  2'd0, 1, 2);
    // MUL/DIV held throughout: 3 stall cycles, release ignores the request.
    muldivVec(1, 2'd0, 2);
    muldivVec(1, 2'd1, 3);
    muldivVec(1, 2'd1, 4);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, C_RUN, 2'd2, 1, 5);
    idle(C_RUN, 2'd0, 5);
    // DMEM freeze for 5 cycles in the middle of the wait.
    muldivVec(1, 2'd0, 5);
    muldivVec(0, 2'd1, 6);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, C_FRZ, 2'd1, 1, 32'(7 + i));
    end
    muldivVec(0, 2'd1, 12);
    idle(C_RUN, 2'd2, 13);
    idle(C_RUN, 2'd0, 13);
    // IMEM miss for 2 cycles.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, C_IM, 2'd0, 1, 13);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, C_IM, 2'd0, 1, 14);
    idle(C_RUN, 2'd0, 15);
    // Branch taken during the release cycle still flushes.
    muldivVec(1, 2'd0, 15);
    muldivVec(1, 2'd1, 16);
    muldivVec(1, 2'd1, 17);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0, C_BR, 2'd2, 1, 18);
    idle(C_RUN, 2'd0, 18);
    // DMEM freeze outranks a branch in RUN.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, C_FRZ, 2'd0, 1, 18);
    // Reset in the middle of a wait aborts the op.
    muldivVec(1, 2'd0, 19);
    muldivVec(0, 2'd1, 20);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 2'd1, 1, 21);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 2'd0, 1, 0);
    idle(C_RUN, 2'd0, 0);
    // Load-use outranks an IMEM miss.
    applyStimulus(0, 9, 0, 9, 1, 0, 0, 1, 0, C_LU, 2'd0, 1, 0);
    idle(C_RUN, 2'd0, 1);

    @(posedge CLK);
    #1;
    vecValid = 1'b0;
    repeat (2) @(posedge CLK);
    if (expQ.size() != 0) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
